// File: rtl/step_dir_decoder.sv
// Step/direction input decoder: synchronized, glitch-filtered step and dir drive a signed
// position, a step counter and stall detection. Define STEP_DIR_DECODER_PERIOD_EN to add step-period capture.
module step_dir_decoder #(
    parameter int unsigned FILT_LEN    = 4,
    parameter int unsigned DIR_SETUP   = 8,
    parameter logic [31:0] STALL_COUNT = 32'h00FF_FFFF
) (
    input  logic        clk_i,
    input  logic        reset,
    input  logic        step_i,
    input  logic        dir_i,
    input  logic        wr_pos,
    input  logic [31:0] pos_i,
    input  logic        wr_clr,
    input  logic [2:0]  raddr_i,
    output logic [31:0] rdata,
    output logic        step_evt,
    output logic        setup_err,
    output logic        stalled
);

    typedef enum logic {ST_LOW, ST_HIGH} state_t;

    localparam logic [7:0]  FILT_LAST   = 8'(FILT_LEN - 1);
    localparam logic [31:0] DIR_SETUP_W = 32'(DIR_SETUP);

    logic [1:0] raw_in;
    logic [1:0] filt;
    logic [1:0] filt_chg;

    assign raw_in = {dir_i, step_i};

    // Bit 0 is step, bit 1 is dir; both take the same path so their relative timing is preserved.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_in
            logic       sync1_reg;
            logic       sync2_reg;
            logic       filt_reg;
            logic [7:0] cnt_reg;

            assign filt[gi]     = filt_reg;
            assign filt_chg[gi] = (sync2_reg != filt_reg) && (cnt_reg == FILT_LAST);

            always_ff @(posedge clk_i or posedge reset) begin
                if (reset) begin
                    sync1_reg <= 1'b0;
                    sync2_reg <= 1'b0;
                    filt_reg  <= 1'b0;
                    cnt_reg   <= 8'd0;
                end else begin
                    sync1_reg <= raw_in[gi];
                    sync2_reg <= sync1_reg;
                    if (sync2_reg == filt_reg) begin
                        cnt_reg <= 8'd0;
                    end else if (cnt_reg == FILT_LAST) begin
                        filt_reg <= sync2_reg;
                        cnt_reg  <= 8'd0;
                    end else begin
                        cnt_reg <= cnt_reg + 8'd1;
                    end
                end
            end
        end
    endgenerate

    logic filt_step;
    logic filt_dir;
    assign filt_step = filt[0];
    assign filt_dir  = filt[1];

    state_t      state_reg;
    logic        step_evt_reg;
    logic        viol_reg;
    logic        step_dir_reg;
    logic [31:0] dir_stable_reg;

    always_ff @(posedge clk_i or posedge reset) begin
        if (reset) begin
            dir_stable_reg <= 32'd0;
        end else if (filt_chg[1]) begin
            dir_stable_reg <= 32'd0;
        end else if (dir_stable_reg != 32'hFFFF_FFFF) begin
            dir_stable_reg <= dir_stable_reg + 32'd1;
        end
    end

    // Setup violation and direction are captured at the accepting edge and applied with step_evt.
    always_ff @(posedge clk_i or posedge reset) begin
        if (reset) begin
            state_reg    <= ST_LOW;
            step_evt_reg <= 1'b0;
            viol_reg     <= 1'b0;
            step_dir_reg <= 1'b0;
        end else begin
            step_evt_reg <= 1'b0;
            case (state_reg)
                ST_LOW: begin
                    if (filt_step) begin
                        state_reg    <= ST_HIGH;
                        step_evt_reg <= 1'b1;
                        viol_reg     <= (dir_stable_reg < DIR_SETUP_W);
                        step_dir_reg <= filt_dir;
                    end
                end
                ST_HIGH: begin
                    if (!filt_step) begin
                        state_reg <= ST_LOW;
                    end
                end
                default: state_reg <= ST_LOW;
            endcase
        end
    end

    logic        accept;
    logic [31:0] pos_base;
    logic [31:0] pos_reg;
    logic [31:0] count_reg;
    logic [31:0] since_reg;
    logic        setup_err_reg;
    logic        stalled_reg;
    logic [31:0] period;
    logic [31:0] rdata_reg;

    assign accept   = step_evt_reg;
    assign pos_base = wr_pos ? pos_i : pos_reg;

    always_ff @(posedge clk_i or posedge reset) begin
        if (reset) begin
            pos_reg       <= 32'd0;
            count_reg     <= 32'd0;
            since_reg     <= 32'd0;
            setup_err_reg <= 1'b0;
            stalled_reg   <= 1'b0;
        end else begin
            if (accept) begin
                pos_reg <= step_dir_reg ? pos_base + 32'd1 : pos_base - 32'd1;
            end else begin
                pos_reg <= pos_base;
            end

            if (wr_clr) begin
                count_reg     <= accept ? 32'd1 : 32'd0;
                setup_err_reg <= 1'b0;
            end else begin
                if (accept) begin
                    count_reg <= count_reg + 32'd1;
                end
                if (accept && viol_reg) begin
                    setup_err_reg <= 1'b1;
                end
            end

            if (accept) begin
                since_reg <= 32'd1;
            end else if (since_reg != 32'hFFFF_FFFF) begin
                since_reg <= since_reg + 32'd1;
            end

            if (accept) begin
                stalled_reg <= 1'b0;
            end else if (since_reg >= STALL_COUNT) begin
                stalled_reg <= 1'b1;
            end
        end
    end

`ifdef STEP_DIR_DECODER_PERIOD_EN
    logic [31:0] period_reg;

    always_ff @(posedge clk_i or posedge reset) begin
        if (reset) begin
            period_reg <= 32'd0;
        end else if (accept) begin
            period_reg <= since_reg;
        end else if (wr_clr) begin
            period_reg <= 32'd0;
        end
    end

    assign period = period_reg;
`else
    assign period = 32'd0;
`endif

    always_ff @(posedge clk_i or posedge reset) begin
        if (reset) begin
            rdata_reg <= 32'd0;
        end else begin
            case (raddr_i)
                3'd0:    rdata_reg <= {29'd0, state_reg == ST_HIGH, filt_dir, stalled_reg};
                3'd1:    rdata_reg <= pos_reg;
                3'd2:    rdata_reg <= count_reg;
                3'd3:    rdata_reg <= period;
                3'd4:    rdata_reg <= {31'd0, setup_err_reg};
                default: rdata_reg <= 32'd0;
            endcase
        end
    end

    assign rdata     = rdata_reg;
    assign step_evt  = step_evt_reg;
    assign setup_err = setup_err_reg;
    assign stalled   = stalled_reg;

endmodule

// File: tb/tb_step_dir_decoder.sv
// Directed bench for step_dir_decoder: position, counting, glitch rejection, setup
// violations, period and stall, and reset in the middle of a step pulse.
module tb_step_dir_decoder;

    logic        clk_i = 1'b0;
    logic        reset = 1'b1;
    logic        step_i = 1'b0;
    logic        dir_i = 1'b0;
    logic        wr_pos = 1'b0;
    logic [31:0] pos_i = 32'd0;
    logic        wr_clr = 1'b0;
    logic [2:0]  raddr_i = 3'd0;
    logic [31:0] rdata;
    logic        step_evt;
    logic        setup_err;
    logic        stalled;

    int checks = 0;
    int failures = 0;
    int evt_cnt = 0;
    int evt_base;
    int lat;
    logic [31:0] d;
    logic [31:0] exp_period;

    step_dir_decoder #(
        .FILT_LEN    (4),
        .DIR_SETUP   (8),
        .STALL_COUNT (32'd200)
    ) dut (
        .clk_i     (clk_i),
        .reset     (reset),
        .step_i    (step_i),
        .dir_i     (dir_i),
        .wr_pos    (wr_pos),
        .pos_i     (pos_i),
        .wr_clr    (wr_clr),
        .raddr_i   (raddr_i),
        .rdata     (rdata),
        .step_evt  (step_evt),
        .setup_err (setup_err),
        .stalled   (stalled)
    );

    always #5 clk_i = ~clk_i;

    always @(negedge clk_i) begin
        if (step_evt === 1'b1) evt_cnt++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic rd(input logic [2:0] a, output logic [31:0] v);
        @(negedge clk_i);
        raddr_i = a;
        @(posedge clk_i);
        #1 v = rdata;
    endtask

    // Step high for hi cycles then low for lo cycles; lat = posedge index of step_evt (-1 if none).
    task automatic pulse(input int hi, input int lo, output int l);
        l = -1;
        @(negedge clk_i);
        step_i = 1'b1;
        for (int c = 1; c <= hi + lo; c++) begin
            @(posedge clk_i);
            #1;
            if (step_evt === 1'b1 && l < 0) l = c;
            if (c == hi) begin
                @(negedge clk_i);
                step_i = 1'b0;
            end
        end
    endtask

    initial begin
`ifdef STEP_DIR_DECODER_PERIOD_EN
        exp_period = 32'd100;
`else
        exp_period = 32'd0;
`endif
        dir_i = 1'b1;
        repeat (3) @(negedge clk_i);
        reset = 1'b0;
        #1;
        chk("reset_rdata", rdata, 32'd0);
        chk("reset_step_evt", {31'd0, step_evt}, 32'd0);
        chk("reset_setup_err", {31'd0, setup_err}, 32'd0);
        chk("reset_stalled", {31'd0, stalled}, 32'd0);
        rd(3'd1, d); chk("reset_pos", d, 32'd0);
        rd(3'd2, d); chk("reset_count", d, 32'd0);
        repeat (20) @(negedge clk_i);

        // Ten clean 20-cycle pulses, dir=1
        evt_base = evt_cnt;
        pulse(10, 10, lat);
        chk("step_latency", lat, 32'd7);
        for (int i = 1; i < 10; i++) pulse(10, 10, lat);
        chk("ten_evt", evt_cnt - evt_base, 32'd10);
        rd(3'd1, d); chk("ten_pos", d, 32'd10);
        rd(3'd2, d); chk("ten_count", d, 32'd10);
        rd(3'd4, d); chk("ten_setup_err", d, 32'd0);
        chk("ten_stalled", {31'd0, stalled}, 32'd0);

        // Two-cycle glitch is rejected
        evt_base = evt_cnt;
        pulse(2, 12, lat);
        chk("glitch_evt", evt_cnt - evt_base, 32'd0);
        rd(3'd1, d); chk("glitch_pos", d, 32'd10);

        // Signed wrap through 7FFFFFFF
        @(negedge clk_i);
        wr_pos = 1'b1;
        pos_i = 32'h7FFF_FFFF;
        @(negedge clk_i);
        wr_pos = 1'b0;
        rd(3'd1, d); chk("wr_pos_load", d, 32'h7FFF_FFFF);
        pulse(10, 10, lat);
        rd(3'd1, d); chk("wrap_up", d, 32'h8000_0000);
        @(negedge clk_i);
        dir_i = 1'b0;
        repeat (20) @(negedge clk_i);
        pulse(10, 10, lat);
        rd(3'd1, d); chk("wrap_down", d, 32'h7FFF_FFFF);
        chk("no_setup_err", {31'd0, setup_err}, 32'd0);

        // Direction changed three cycles before the step edge
        @(negedge clk_i);
        dir_i = 1'b1;
        repeat (2) @(negedge clk_i);
        evt_base = evt_cnt;
        pulse(10, 10, lat);
        chk("viol_evt", evt_cnt - evt_base, 32'd1);
        chk("viol_setup_err", {31'd0, setup_err}, 32'd1);
        rd(3'd4, d); chk("viol_reg4", d, 32'd1);
        rd(3'd1, d); chk("viol_pos", d, 32'h8000_0000);
        rd(3'd2, d); chk("viol_count", d, 32'd13);
        @(negedge clk_i);
        wr_clr = 1'b1;
        @(negedge clk_i);
        wr_clr = 1'b0;
        #1;
        chk("clr_setup_err", {31'd0, setup_err}, 32'd0);
        rd(3'd2, d); chk("clr_count", d, 32'd0);
        rd(3'd3, d); chk("clr_period", d, 32'd0);

        // Steps 100 cycles apart, then a stall
        pulse(10, 90, lat);
        pulse(10, 90, lat);
        rd(3'd3, d); chk("period_100", d, exp_period);
        rd(3'd1, d); chk("period_pos", d, 32'h8000_0002);
        rd(3'd2, d); chk("period_count", d, 32'd2);
        chk("not_stalled", {31'd0, stalled}, 32'd0);
        repeat (250) @(negedge clk_i);
        chk("stalled_set", {31'd0, stalled}, 32'd1);
        rd(3'd0, d); chk("status_stalled", d, 32'h3);
        rd(3'd6, d); chk("unmapped_addr", d, 32'd0);
        pulse(10, 10, lat);
        chk("stalled_clr", {31'd0, stalled}, 32'd0);
        rd(3'd0, d); chk("status_running", d, 32'h2);

        // Reset while step_i is high; the held level counts once after release
        @(negedge clk_i);
        step_i = 1'b1;
        repeat (3) @(negedge clk_i);
        reset = 1'b1;
        repeat (2) @(negedge clk_i);
        reset = 1'b0;
        evt_base = evt_cnt;
        repeat (20) @(negedge clk_i);
        step_i = 1'b0;
        repeat (10) @(negedge clk_i);
        chk("midreset_evt", evt_cnt - evt_base, 32'd1);
        rd(3'd2, d); chk("midreset_count", d, 32'd1);
        rd(3'd1, d); chk("midreset_pos", d, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/step_dir_decoder.md
STEP_DIR_DECODER -- requirements
Module: step_dir_decoder

Interface
REQ-001 SHALL have parameter FILT_LEN, default 4: consecutive synchronized cycles an input must hold before the filtered value changes (1..255).
REQ-002 SHALL have parameter DIR_SETUP, default 8: minimum cycles filtered dir must be stable before a filtered step rising edge.
REQ-003 SHALL have parameter STALL_COUNT, default 32'h00FF_FFFF: cycles without a step before the stalled flag sets.
REQ-004 SHALL use one clock and an asynchronous, active-high reset.
REQ-005 clk_i  input  1  system clock; all logic on its rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 step_i  input  1  asynchronous step pulse from the driver pins.
REQ-008 dir_i  input  1  asynchronous direction; 1 = increment position.
REQ-009 wr_pos  input  1  load strobe for pos_i, single-cycle pulse.
REQ-010 pos_i  input  32  position preset value.
REQ-011 wr_clr  input  1  clears step_count, setup_err and period, single-cycle pulse.
REQ-012 raddr_i  input  3  read address.
REQ-013 rdata  output  32  registered read data.
REQ-014 step_evt  output  1  one-cycle pulse per accepted step.
REQ-015 setup_err  output  1  sticky direction-setup violation flag.
REQ-016 stalled  output  1  no step for STALL_COUNT cycles.

Function
REQ-017 SHALL pass step_i and dir_i through two-flop synchronizers, then through a FILT_LEN glitch filter with a per-input 8-bit counter.
REQ-018 SHALL run a step FSM with states ST_LOW and ST_HIGH on filtered step: ST_LOW->ST_HIGH on filtered 1 (accepted step), ST_HIGH->ST_LOW on filtered 0.
REQ-019 SHALL assert step_evt exactly FILT_LEN+3 cycles after a clean step_i rise, with position updated on the following cycle.
REQ-020 SHALL update pos (signed 32-bit) by +1 if filtered dir=1, else -1, wrapping modulo 2^32 (7FFFFFFF+1 -> 80000000).
REQ-021 SHALL increment unsigned 32-bit step_count per accepted step, wrapping FFFFFFFF -> 0.
REQ-022 SHALL track dir-stable cycles in a saturating counter, reset on any filtered dir change; a step accepted with that count < DIR_SETUP sets setup_err and is still counted using the current filtered dir.
REQ-023 SHALL count cycles since the last accepted step in a 32-bit saturating counter, reset to 1 on each step.
REQ-024 SHALL set stalled when that counter reaches STALL_COUNT and clear it on the next accepted step.
REQ-025 SHALL load pos_i on wr_pos; if a step is accepted the same cycle, pos = pos_i +/- 1.
REQ-026 SHALL on wr_clr zero step_count, setup_err and period; a simultaneous step makes step_count 1 and leaves setup_err at 0.
REQ-027 SHALL register rdata one cycle after raddr_i as follows.
- 0: {29'b0, state, filtered dir, stalled}
- 1: pos
- 2: step_count
- 3: period
- 4: {31'b0, setup_err}
- others: 0

Reset
REQ-028 SHALL on reset clear asynchronously the following:
- pos, step_count, period, counters and filters to 0
- FSM to ST_LOW
- step_evt, setup_err, stalled and rdata to 0
REQ-029 SHALL, on reset asserted mid-pulse with step_i still high after release, require the filter to see the input high for FILT_LEN cycles and then count one step.

Configuration
REQ-030 SHALL, when macro STEP_DIR_DECODER_PERIOD_EN is defined, latch the since-last-step counter into period on each accepted step (saturated at FFFFFFFF).
REQ-031 SHALL, without STEP_DIR_DECODER_PERIOD_EN, omit period logic, reading address 3 as 0; stall detection remains.

Verification
REQ-032 Reset, then 10 clean 20-cycle pulses with dir_i=1 -> pos=10, step_count=10, 10 step_evt pulses, setup_err=0.
REQ-033 2-cycle glitch on step_i with FILT_LEN=4 -> no step_evt, pos unchanged.
REQ-034 wr_pos pos_i=7FFFFFFF, then one step dir=1 -> pos=80000000; one step dir=0 -> pos=7FFFFFFF.
REQ-035 dir_i toggled 3 cycles before the filtered step edge (DIR_SETUP=8) -> setup_err=1 and the step is counted; wr_clr -> setup_err=0, step_count=0.
REQ-036 Steps 100 cycles apart with STEP_DIR_DECODER_PERIOD_EN -> period reads 100; with no steps for STALL_COUNT cycles -> stalled=1; the next step -> stalled=0.
